// File: rtl/press_event_decoder.sv
// press_event_decoder: turns T1 (short press) and T2 (long hold) into registered 1-cycle short/double/long_start/long_repeat/long_end pulses, busy and an 8-bit event_count
module press_event_decoder #(
  parameter int DOUBLE_WIN    = 30_000_000,
  parameter int REPEAT_PERIOD = 20_000_000,
  parameter int CNT_W         = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       T1,
  input  logic       T2,
  output logic       short_press,
  output logic       double_press,
  output logic       long_start,
  output logic       long_repeat,
  output logic       long_end,
  output logic       busy,
  output logic [7:0] event_count
);
  typedef enum logic [1:0] {IDLE, WAIT2, LONG} state_t;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DOUBLE_WIN - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  state_t state, state_nx;
  logic t1_q, t2_q;
  logic [CNT_W-1:0] win_cnt, rep_cnt, win_nx, rep_nx;
  logic s_nx, d_nx, ls_nx, lr_nx, le_nx;
  logic t1_rise, t2_rise, t2_fall;
  assign t1_rise = T1 & ~t1_q;
  assign t2_rise = T2 & ~t2_q;
  assign t2_fall = ~T2 & t2_q;
  always_comb begin
    state_nx = state;
    win_nx   = win_cnt;
    rep_nx   = rep_cnt;
    s_nx     = 1'b0;
    d_nx     = 1'b0;
    ls_nx    = 1'b0;
    lr_nx    = 1'b0;
    le_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (t2_rise) begin
          ls_nx    = 1'b1;
          rep_nx   = '0;
          state_nx = LONG;
        end else if (t1_rise) begin
          win_nx   = '0;
          state_nx = WAIT2;
        end
      end
      WAIT2: begin
        win_nx = win_cnt + 1'b1;
        if (t1_rise) begin
          d_nx     = 1'b1;
          state_nx = IDLE;
        end else if (t2_rise) begin
          s_nx     = 1'b1;
          ls_nx    = 1'b1;
          rep_nx   = '0;
          state_nx = LONG;
        end else if (win_cnt == WIN_LAST) begin
          s_nx     = 1'b1;
          state_nx = IDLE;
        end
      end
      LONG: begin
        rep_nx = rep_cnt + 1'b1;
        if (t2_fall) begin
          le_nx    = 1'b1;
          state_nx = IDLE;
        end else if (rep_cnt == REP_LAST) begin
          lr_nx  = 1'b1;
          rep_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      t1_q         <= 1'b0;
      t2_q         <= 1'b0;
      win_cnt      <= '0;
      rep_cnt      <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_start   <= 1'b0;
      long_repeat  <= 1'b0;
      long_end     <= 1'b0;
      busy         <= 1'b0;
      event_count  <= '0;
    end else begin
      state        <= state_nx;
      t1_q         <= T1;
      t2_q         <= T2;
      win_cnt      <= win_nx;
      rep_cnt      <= rep_nx;
      short_press  <= s_nx;
      double_press <= d_nx;
      long_start   <= ls_nx;
      long_repeat  <= lr_nx;
      long_end     <= le_nx;
      busy         <= state_nx != IDLE;
      event_count  <= event_count + 8'(s_nx) + 8'(d_nx) + 8'(ls_nx);
    end
  end
endmodule

// File: tb/tb_press_event_decoder.sv
// tb_press_event_decoder: directed scenario table, reset-in-hold sequence and random run against a timestamp model
module tb_press_event_decoder;
  localparam int DW = 10;
  localparam int RP = 4;
  logic clk = 1'b0, reset = 1'b0, T1 = 1'b0, T2 = 1'b0;
  logic short_press, double_press, long_start, long_repeat, long_end, busy;
  logic [7:0] event_count;
  logic [13:0] dut_v;
  int total = 0, bad = 0;
  press_event_decoder #(.DOUBLE_WIN(DW), .REPEAT_PERIOD(RP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .T1(T1), .T2(T2),
    .short_press(short_press), .double_press(double_press), .long_start(long_start),
    .long_repeat(long_repeat), .long_end(long_end), .busy(busy), .event_count(event_count)
  );
  assign dut_v = {short_press, double_press, long_start, long_repeat, long_end, busy, event_count};
  always #5 clk = ~clk;
  typedef struct {
    int t1a, t1b, t2r, t2f;
    int e_short, e_double, e_ls, e_le, e_rep_n, e_rep_first, e_events, e_busy_first, e_busy_last;
  } vec_t;
  vec_t vecs[5];
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    T1 = 1'b0;
    T2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  int m_now, m_press, m_hold, m_cnt;
  logic m_p1, m_p2;
  task automatic model_reset();
    m_now = 0;
    m_press = -1;
    m_hold = -1;
    m_cnt = 0;
    m_p1 = 1'b0;
    m_p2 = 1'b0;
  endtask
  function automatic logic [13:0] model_step(input logic t1, input logic t2);
    logic r1, r2, f2, s, d, ls, lr, le;
    r1 = t1 & ~m_p1;
    r2 = t2 & ~m_p2;
    f2 = ~t2 & m_p2;
    {s, d, ls, lr, le} = '0;
    if (m_hold >= 0) begin
      if (f2) begin
        le = 1'b1;
        m_hold = -1;
      end else if ((m_now - m_hold) % RP == 0) lr = 1'b1;
    end else if (m_press >= 0) begin
      if (r1) begin
        d = 1'b1;
        m_press = -1;
      end else if (r2) begin
        s = 1'b1;
        ls = 1'b1;
        m_press = -1;
        m_hold = m_now;
      end else if (m_now - m_press == DW) begin
        s = 1'b1;
        m_press = -1;
      end
    end else if (r2) begin
      ls = 1'b1;
      m_hold = m_now;
    end else if (r1) m_press = m_now;
    m_cnt = (m_cnt + int'(s) + int'(d) + int'(ls)) % 256;
    m_p1 = t1;
    m_p2 = t2;
    m_now++;
    return {s, d, ls, lr, le, (m_press >= 0 || m_hold >= 0), 8'(m_cnt)};
  endfunction
  initial begin
    int f_s, f_d, f_ls, f_le, f_r, n_s, n_d, n_ls, n_le, n_r, b_first, b_last;
    logic [13:0] exp_v;
    logic rt1, rt2;
    vecs[0] = '{5, -1, -1, -1, 16, -1, -1, -1, 0, -1, 1, 6, 15};
    vecs[1] = '{5, 9, -1, -1, -1, 10, -1, -1, 0, -1, 1, 6, 9};
    vecs[2] = '{5, 15, -1, -1, -1, 16, -1, -1, 0, -1, 1, 6, 15};
    vecs[3] = '{-1, -1, 20, 38, -1, -1, 21, 39, 4, 25, 1, 21, 38};
    vecs[4] = '{5, -1, 8, 12, 9, -1, 9, 13, 0, -1, 2, 6, 12};
    repeat (2) @(negedge clk);
    check("reset_state", int'(dut_v), 0);
    for (int i = 0; i < 5; i++) begin
      apply_reset();
      {f_s, f_d, f_ls, f_le, f_r, b_first, b_last} = {7{-32'sd1}};
      {n_s, n_d, n_ls, n_le, n_r} = '0;
      for (int c = 0; c < 45; c++) begin
        @(negedge clk);
        T1 = (c == vecs[i].t1a) || (c == vecs[i].t1b);
        T2 = vecs[i].t2r >= 0 && c >= vecs[i].t2r && c < vecs[i].t2f;
        @(posedge clk);
        #1;
        if (short_press) begin n_s++; if (f_s < 0) f_s = c + 1; end
        if (double_press) begin n_d++; if (f_d < 0) f_d = c + 1; end
        if (long_start) begin n_ls++; if (f_ls < 0) f_ls = c + 1; end
        if (long_end) begin n_le++; if (f_le < 0) f_le = c + 1; end
        if (long_repeat) begin n_r++; if (f_r < 0) f_r = c + 1; end
        if (busy) begin if (b_first < 0) b_first = c + 1; b_last = c + 1; end
      end
      check($sformatf("v%0d short_cyc", i), f_s, vecs[i].e_short);
      check($sformatf("v%0d short_n", i), n_s, vecs[i].e_short < 0 ? 0 : 1);
      check($sformatf("v%0d double_cyc", i), f_d, vecs[i].e_double);
      check($sformatf("v%0d double_n", i), n_d, vecs[i].e_double < 0 ? 0 : 1);
      check($sformatf("v%0d lstart_cyc", i), f_ls, vecs[i].e_ls);
      check($sformatf("v%0d lstart_n", i), n_ls, vecs[i].e_ls < 0 ? 0 : 1);
      check($sformatf("v%0d lend_cyc", i), f_le, vecs[i].e_le);
      check($sformatf("v%0d lend_n", i), n_le, vecs[i].e_le < 0 ? 0 : 1);
      check($sformatf("v%0d rep_n", i), n_r, vecs[i].e_rep_n);
      check($sformatf("v%0d rep_first", i), f_r, vecs[i].e_rep_first);
      check($sformatf("v%0d events", i), int'(event_count), vecs[i].e_events);
      check($sformatf("v%0d busy_first", i), b_first, vecs[i].e_busy_first);
      check($sformatf("v%0d busy_last", i), b_last, vecs[i].e_busy_last);
    end
    apply_reset();
    @(negedge clk);
    T2 = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("rst_async_outs", int'(dut_v), 0);
    @(negedge clk);
    check("rst_held_outs", int'(dut_v), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_lstart", int'(long_start), 1);
    check("rst_rel_busy", int'(busy), 1);
    check("rst_rel_events", int'(event_count), 1);
    @(posedge clk);
    #1;
    check("rst_rel_lstart_pulse", int'(long_start), 0);
    apply_reset();
    model_reset();
    rt1 = 1'b0;
    rt2 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rt1 = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 11) == 0) rt2 = ~rt2;
      T1 = rt1;
      T2 = rt2;
      exp_v = model_step(rt1, rt2);
      @(posedge clk);
      #1;
      check($sformatf("rand c%0d", c), int'(dut_v), int'(exp_v));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
